pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Consumer end of the branch decision interface: takes the 2-bit `branch` decision from `branch_unit` plus the computed target, and owns the fetch program counter.
- Sequences linear fetch (PC+4), redirects on taken branch/jump, and squashes wrong-path fetches for a fixed number of cycles.
- Traps on misaligned targets.
- Sits between `branch_unit` (EX stage) and the instruction-memory fetch port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles `if_valid` is held low after a redirect; legal range 1..15.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- branch  input  2  decision from branch_unit; bit0 = conditional branch taken, bit1 = unconditional jump; nonzero = redirect request.
- branch_target  input  32  redirect target address, valid when branch != 0.
- stall  input  1  pipeline stall; freezes PC advance.
- if_ready  input  1  fetch port accepts current PC this cycle.
- pc  output  32  current fetch PC.
- if_valid  output  1  pc is a valid fetch request.
- flush  output  1  one-cycle pulse; squash younger IF/ID instructions.
- misalign_trap  output  1  sticky; target[1:0] != 0 was seen.
- trap_addr  output  32  offending target captured at trap.
- redirect_cnt  output  CNT_W  saturating count of accepted redirects.

Behaviour:
- Reset (rst=1 at a clock edge), all registered:
  - pc=RESET_PC, state=BOOT
  - if_valid=0, flush=0, misalign_trap=0
  - trap_addr=0, redirect_cnt=0, flush counter=0
  - Reset asserted in any state, including mid-FLUSH or TRAP, returns to these values next edge.
- States: BOOT, RUN, FLUSH, TRAP.
- BOOT:
  - Lasts exactly one cycle, then RUN.
  - `branch` is ignored.
  - if_valid=0.
- RUN:
  - if_valid=1.
  - Priority 1, aligned redirect (branch != 0, target[1:0]==0):
    - pc <= branch_target; flush=1 for exactly that next cycle.
    - Load flush counter with FLUSH_CYCLES; go to FLUSH.
    - redirect_cnt += 1, saturating at all-ones.
    - Applies even when stall=1 or if_ready=0.
  - Priority 1, misaligned redirect (branch != 0, target[1:0] != 0):
    - misalign_trap <= 1; trap_addr <= branch_target.
    - pc unchanged; go to TRAP.
    - No flush pulse; redirect_cnt unchanged.
  - Priority 2, advance (branch==0, if_ready=1, stall=0):
    - pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
  - Otherwise: pc holds.
  - branch=2'b11 is treated identically to any nonzero value.
- FLUSH:
  - if_valid=0; pc holds at the target.
  - Counter decrements each cycle; returns to RUN on the cycle after the counter reaches 1.
  - Result: if_valid is low for exactly FLUSH_CYCLES cycles after the redirect edge.
  - `branch` is ignored (wrong-path result); stall and if_ready have no effect.
  - flush is high only in the first FLUSH cycle.
- TRAP:
  - if_valid=0, pc frozen, all inputs ignored.
  - Exit only via rst.
- Latency:
  - Redirect request at edge N → pc=target after edge N.
  - First valid fetch of target at edge N+FLUSH_CYCLES.
- Outputs change only on clk edges.

Test Plan:
- Reset/boot: rst high 2 cycles, then low, if_ready=1, stall=0 → cycle 0 pc=0, if_valid=0; then RUN with pc 0,4,8,C on successive cycles and if_valid=1.
- Stall: in RUN at pc=8, stall=1 for 3 cycles → pc stays 8, if_valid=1; on release pc=C next cycle. Repeat with if_ready=0 → same hold.
- Taken branch: pc=10, branch=2'b01, target=32'h100 → next cycle pc=100, flush=1 for one cycle, if_valid=0 for 2 cycles, then if_valid=1 and pc 100→104; redirect_cnt=1. Also branch=2'b10 with stall=1 → redirect still taken.
- Branch during flush: redirect to 0x200, then branch=2'b01 target 0x300 on the next cycle → ignored, pc stays 200, redirect_cnt increments once only.
- Misaligned: branch=2'b10, target=32'h102 → misalign_trap=1, trap_addr=102, pc unchanged, if_valid=0 indefinitely despite further branches; rst → all reset values.
- Wrap/saturate: RESET_PC=32'hFFFF_FFF8 → pc FFF8, FFFC, 0000. CNT_W=2 with 5 redirects → redirect_cnt=3.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: linear PC+4 sequencing, branch/jump redirects with a fixed
// wrong-path squash window, and a sticky trap on misaligned redirect targets.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       branch,
    input  logic [31:0]      branch_target,
    input  logic             stall,
    input  logic             if_ready,
    output logic [31:0]      pc,
    output logic             if_valid,
    output logic             flush,
    output logic             misalign_trap,
    output logic [31:0]      trap_addr,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        TRAP  = 2'd3
    } state_t;

    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state, state_nxt;
    logic [3:0]       fcnt, fcnt_nxt;
    logic [31:0]      pc_nxt, trap_addr_nxt;
    logic             flush_nxt, trap_nxt, if_valid_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    logic redirect_req, target_aligned;
    assign redirect_req   = (branch != 2'b00);
    assign target_aligned = (branch_target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            fcnt          <= '0;
            pc            <= RESET_PC;
            if_valid      <= 1'b0;
            flush         <= 1'b0;
            misalign_trap <= 1'b0;
            trap_addr     <= '0;
            redirect_cnt  <= '0;
        end else begin
            state         <= state_nxt;
            fcnt          <= fcnt_nxt;
            pc            <= pc_nxt;
            if_valid      <= if_valid_nxt;
            flush         <= flush_nxt;
            misalign_trap <= trap_nxt;
            trap_addr     <= trap_addr_nxt;
            redirect_cnt  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fcnt_nxt      = fcnt;
        pc_nxt        = pc;
        flush_nxt     = 1'b0;
        trap_nxt      = misalign_trap;
        trap_addr_nxt = trap_addr;
        cnt_nxt       = redirect_cnt;

        case (state)
            BOOT: state_nxt = RUN;

            RUN: begin
                // Redirects win over stall/if_ready: the wrong path must die now.
                if (redirect_req) begin
                    if (target_aligned) begin
                        pc_nxt    = branch_target;
                        flush_nxt = 1'b1;
                        fcnt_nxt  = FLUSH_LOAD;
                        state_nxt = FLUSH;
                        if (redirect_cnt != CNT_MAX)
                            cnt_nxt = redirect_cnt + 1'b1;
                    end else begin
                        trap_nxt      = 1'b1;
                        trap_addr_nxt = branch_target;
                        state_nxt     = TRAP;
                    end
                end else if (if_ready && !stall) begin
                    pc_nxt = pc + 32'd4;
                end
            end

            FLUSH: begin
                // Counter value 1 marks the last squashed cycle.
                if (fcnt <= 4'd1) begin
                    fcnt_nxt  = '0;
                    state_nxt = RUN;
                end else begin
                    fcnt_nxt = fcnt - 4'd1;
                end
            end

            TRAP: state_nxt = TRAP;

            default: state_nxt = BOOT;
        endcase

        if_valid_nxt = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed scenarios plus random traffic against a
// cycle-level behavioural model; a second instance covers PC wrap and counter saturation.
module tb_pc_redirect_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst, stall, if_ready;
    logic [1:0]  branch;
    logic [31:0] branch_target;
    logic [31:0] pc, trap_addr;
    logic        if_valid, flush, misalign_trap;
    logic [15:0] redirect_cnt;

    pc_redirect_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .branch(branch), .branch_target(branch_target),
        .stall(stall), .if_ready(if_ready), .pc(pc), .if_valid(if_valid),
        .flush(flush), .misalign_trap(misalign_trap), .trap_addr(trap_addr),
        .redirect_cnt(redirect_cnt));

    // wrap / saturation instance
    logic        rst2;
    logic [1:0]  branch2;
    logic [31:0] target2;
    logic [31:0] pc2, trap_addr2;
    logic        if_valid2, flush2, trap2;
    logic [1:0]  cnt2;

    pc_redirect_unit #(.RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .branch(branch2), .branch_target(target2),
        .stall(1'b0), .if_ready(1'b1), .pc(pc2), .if_valid(if_valid2),
        .flush(flush2), .misalign_trap(trap2), .trap_addr(trap_addr2),
        .redirect_cnt(cnt2));

    int passed = 0;
    int total  = 0;

    // Behavioural model: tracks how many more squashed cycles remain rather than a state.
    logic [31:0] m_pc, m_taddr;
    bit          m_boot, m_trap, m_flush;
    int          m_blank, m_cnt;

    function automatic void model_step();
        if (rst) begin
            m_pc = 32'h0; m_boot = 1; m_trap = 0; m_flush = 0;
            m_taddr = 0; m_cnt = 0; m_blank = 0;
        end else if (m_trap) begin
            m_flush = 0;
        end else if (m_boot) begin
            m_boot = 0; m_flush = 0;
        end else if (m_blank > 0) begin
            m_blank--; m_flush = 0;
        end else begin
            m_flush = 0;
            if (branch != 0) begin
                if (branch_target % 4 != 0) begin
                    m_trap = 1; m_taddr = branch_target;
                end else begin
                    m_pc = branch_target; m_flush = 1; m_blank = FC;
                    if (m_cnt < 65535) m_cnt++;
                end
            end else if (if_ready && !stall) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("if_valid", 32'(if_valid), 32'(!m_boot && !m_trap && m_blank == 0));
        chk("flush", 32'(flush), 32'(m_flush));
        chk("misalign_trap", 32'(misalign_trap), 32'(m_trap));
        chk("trap_addr", trap_addr, m_taddr);
        chk("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic cycle2();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; if_ready = 1; branch = 0; branch_target = 0;
        rst2 = 1; branch2 = 0; target2 = 0;

        // reset and boot
        cycle(); cycle();
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", 32'(if_valid), 32'h0);
        rst = 0;
        cycle(); chk("run_pc0", pc, 32'h0); chk("run_valid", 32'(if_valid), 32'h1);
        cycle(); chk("run_pc4", pc, 32'h4);
        cycle(); chk("run_pc8", pc, 32'h8);

        // stall, then if_ready low
        stall = 1;
        repeat (3) cycle();
        chk("stall_hold", pc, 32'h8);
        stall = 0; cycle(); chk("stall_rel", pc, 32'hC);
        if_ready = 0;
        repeat (3) cycle();
        chk("rdy_hold", pc, 32'hC);
        if_ready = 1; cycle(); chk("rdy_rel", pc, 32'h10);

        // taken branch at pc=10
        branch = 2'b01; branch_target = 32'h100;
        cycle();
        chk("br_pc", pc, 32'h100); chk("br_flush", 32'(flush), 32'h1);
        chk("br_cnt", 32'(redirect_cnt), 32'h1);
        branch = 0;
        cycle(); chk("br_squash2", 32'(if_valid), 32'h0);
        cycle(); chk("br_first_fetch", 32'(if_valid), 32'h1); chk("br_pc_hold", pc, 32'h100);
        cycle(); chk("br_pc_next", pc, 32'h104);

        // jump under stall
        branch = 2'b10; branch_target = 32'h40; stall = 1;
        cycle(); chk("jmp_stall_pc", pc, 32'h40);
        branch = 0; stall = 0;
        repeat (3) cycle();

        // branch during flush is ignored
        branch = 2'b01; branch_target = 32'h200; cycle();
        branch_target = 32'h300; cycle();
        chk("flush_ign_pc", pc, 32'h200);
        chk("flush_ign_cnt", 32'(redirect_cnt), 32'h3);
        branch = 2'b11; branch_target = 32'h400; cycle();   // last squashed edge, still ignored
        chk("flush_ign_pc2", pc, 32'h200);
        branch = 0; cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(49) == 0);
            stall    = ($urandom_range(3) == 0);
            if_ready = ($urandom_range(3) != 0);
            branch   = ($urandom_range(5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            branch_target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) branch_target[1:0] = 2'($urandom_range(1, 3));
            cycle();
        end

        // misaligned target traps
        rst = 1; branch = 0; stall = 0; if_ready = 1; cycle();
        rst = 0; repeat (4) cycle();
        branch = 2'b10; branch_target = 32'h102; cycle();
        chk("trap_flag", 32'(misalign_trap), 32'h1);
        chk("trap_addr", trap_addr, 32'h102);
        chk("trap_pc", pc, 32'hC);
        chk("trap_flush", 32'(flush), 32'h0);
        branch = 2'b01; branch_target = 32'h500;
        repeat (3) cycle();
        chk("trap_valid", 32'(if_valid), 32'h0);
        chk("trap_pc_frozen", pc, 32'hC);
        branch = 0; rst = 1; cycle();
        chk("trap_rst_flag", 32'(misalign_trap), 32'h0);
        chk("trap_rst_addr", trap_addr, 32'h0);
        chk("trap_rst_cnt", 32'(redirect_cnt), 32'h0);
        rst = 0;

        // wrap and saturation on the second instance (FLUSH_CYCLES=1, CNT_W=2)
        cycle2(); cycle2();
        chk("w_reset_pc", pc2, 32'hFFFF_FFF8);
        rst2 = 0;
        cycle2(); chk("w_pc0", pc2, 32'hFFFF_FFF8); chk("w_valid", 32'(if_valid2), 32'h1);
        cycle2(); chk("w_pc1", pc2, 32'hFFFF_FFFC);
        cycle2(); chk("w_pc_wrap", pc2, 32'h0000_0000);
        for (int k = 1; k <= 5; k++) begin
            branch2 = 2'b01; target2 = 32'h40 * k;
            cycle2();
            chk("s_pc", pc2, 32'h40 * k);
            chk("s_valid_low", 32'(if_valid2), 32'h0);
            branch2 = 0;
            cycle2();
            chk("s_valid_back", 32'(if_valid2), 32'h1);
        end
        chk("s_cnt_sat", 32'(cnt2), 32'h3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
